// File: rtl/adc_sample_sequencer_pkg.sv
// Shared definitions for the LTC2308 sample sequencer: register map,
// STATUS/CONTROL bit positions, sequencer states and the SDI config word.
package adc_sample_sequencer_pkg;

  // Avalon-MM word addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_DATA    = 3'd2;
  localparam logic [2:0] ADDR_LEVEL   = 3'd3;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_MISSED    = 3;

  // CONTROL bit positions
  localparam int CTRL_WIDTH    = 6;
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CH_LSB   = 2;
  localparam int CTRL_CH_MSB   = 4;
  localparam int CTRL_UNIPOLAR = 5;

  // ADC word sizes
  localparam int SAMPLE_BITS = 12;
  localparam int CFG_BITS    = 6;

  // Config word bit layout, shifted out MSB first
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } seqState_e;

  // Builds the single-ended config word for a channel; sleep is never requested.
  function automatic logic [CFG_BITS-1:0] buildCfgWord(input logic [2:0] channel,
                                                       input logic unipolar);
    logic [CFG_BITS-1:0] word;
    word          = '0;
    word[CFG_SD]  = 1'b1;
    word[CFG_OS]  = channel[0];
    word[CFG_S1]  = channel[2];
    word[CFG_S0]  = channel[1];
    word[CFG_UNI] = unipolar;
    word[CFG_SLP] = 1'b0;
    return word;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Small synchronous sample FIFO. A push into a full FIFO is only accepted
// when a pop happens in the same cycle, so the level never exceeds DEPTH.
module adc_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             doPush, doPop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign level_o = level_q;

  // Occupancy only moves when exactly one of push/pop takes effect.
  always_comb begin
    level_d = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + 1'b1;
    end else if (doPop && !doPush) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage array has no reset; entries are only visible once written.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers and level, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Triggered LTC2308 sampler with an Avalon-MM register front end.
// Each accepted trigger runs one CONVST pulse, a 12-clock SPI exchange
// (config word out on SDI, sample in on SDO) and one FIFO push.
module adc_sample_sequencer
  import adc_sample_sequencer_pkg::*;
#(
  parameter int SCK_HALF    = 2,
  parameter int CONV_CYCLES = 80,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] CONV_LOAD = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] HALF_LOAD = 16'(SCK_HALF - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(SAMPLE_BITS - 1);

  seqState_e              state_q;
  logic [15:0]            timer_q;
  logic [3:0]             bitCnt_q;
  logic [2:0]             channel_q;
  logic                   unipolar_q;
  logic [SAMPLE_BITS-1:0] shift_q;
  logic [SAMPLE_BITS-1:0] sdiShift_q;
  logic                   convst_q, sck_q, sdi_q;

  logic [CTRL_WIDTH-1:0]  control_q, control_d;
  logic                   overrun_q, overrun_d;
  logic                   missed_q, missed_d;
  logic [15:0]            readdata_q, readMux;

  logic                   busWrite, busRead;
  logic                   statusWrite, controlWrite, popReq;
  logic                   busy, trigAccept, trigMissed;
  logic                   storePush, pushDropped;
  logic [CFG_BITS-1:0]    cfgWord;
  logic [SAMPLE_BITS-1:0] sdiFrame;
  logic [15:0]            sampleWord;

  logic [15:0]            fifoHead;
  logic                   fifoFull, fifoEmpty;
  logic [LW-1:0]          fifoLevel;

  logic                   unusedWdata;

  assign unusedWdata  = ^writedata[15:CTRL_WIDTH];

  assign busWrite     = chipselect && !write_n;
  assign busRead      = chipselect && !read_n;
  assign statusWrite  = busWrite && (address == ADDR_STATUS);
  assign controlWrite = busWrite && (address == ADDR_CONTROL);
  assign popReq       = busRead && (address == ADDR_DATA);

  assign busy         = (state_q != IDLE);
  assign trigAccept   = trigger && control_q[CTRL_ENABLE] && !busy;
  assign trigMissed   = trigger && control_q[CTRL_ENABLE] && busy;

  assign storePush    = (state_q == STORE);
  // A full FIFO only refuses the push when no pop frees a slot this cycle.
  assign pushDropped  = storePush && fifoFull && !popReq;

  assign cfgWord      = buildCfgWord(channel_q, unipolar_q);
  assign sdiFrame     = {cfgWord, {(SAMPLE_BITS - CFG_BITS){1'b0}}};
  assign sampleWord   = {1'b0, channel_q, shift_q};

  assign adc_convst   = convst_q;
  assign adc_sck      = sck_q;
  assign adc_sdi      = sdi_q;
  assign readdata     = readdata_q;
  assign irq          = control_q[CTRL_IRQ_EN] && (!fifoEmpty || overrun_q);

  adc_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (storePush),
    .pop_i   (popReq),
    .data_i  (sampleWord),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifoLevel)
  );

  // Sequencer: CONVST pulse, then 12 SCK periods (low half first), then one push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitCnt_q   <= '0;
      channel_q  <= '0;
      unipolar_q <= 1'b0;
      shift_q    <= '0;
      sdiShift_q <= '0;
      convst_q   <= 1'b0;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigAccept) begin
            state_q    <= CONV;
            convst_q   <= 1'b1;
            timer_q    <= CONV_LOAD;
            channel_q  <= control_q[CTRL_CH_MSB:CTRL_CH_LSB];
            unipolar_q <= control_q[CTRL_UNIPOLAR];
          end
        end
        CONV: begin
          if (timer_q == '0) begin
            state_q    <= SHIFT;
            convst_q   <= 1'b0;
            timer_q    <= HALF_LOAD;
            bitCnt_q   <= '0;
            sck_q      <= 1'b0;
            sdi_q      <= sdiFrame[SAMPLE_BITS-1];
            sdiShift_q <= {sdiFrame[SAMPLE_BITS-2:0], 1'b0};
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        SHIFT: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            timer_q <= HALF_LOAD;
            if (!sck_q) begin
              sck_q   <= 1'b1;
              shift_q <= {shift_q[SAMPLE_BITS-2:0], adc_sdo};
            end else begin
              sck_q <= 1'b0;
              if (bitCnt_q == LAST_BIT) begin
                state_q <= STORE;
                sdi_q   <= 1'b0;
              end else begin
                bitCnt_q   <= bitCnt_q + 1'b1;
                sdi_q      <= sdiShift_q[SAMPLE_BITS-1];
                sdiShift_q <= {sdiShift_q[SAMPLE_BITS-2:0], 1'b0};
              end
            end
          end
        end
        STORE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // CONTROL and sticky flags; a new event beats a same-cycle STATUS clear.
  always_comb begin
    control_d = control_q;
    overrun_d = overrun_q;
    missed_d  = missed_q;
    if (controlWrite) begin
      control_d = writedata[CTRL_WIDTH-1:0];
    end
    if (statusWrite) begin
      overrun_d = 1'b0;
      missed_d  = 1'b0;
    end
    if (pushDropped) begin
      overrun_d = 1'b1;
    end
    if (trigMissed) begin
      missed_d = 1'b1;
    end
  end

  // Register state update for CONTROL and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control_q <= '0;
      overrun_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      control_q <= control_d;
      overrun_q <= overrun_d;
      missed_q  <= missed_d;
    end
  end

  // Read mux; DATA shows the FIFO head, or 0 when nothing is queued.
  always_comb begin
    readMux = '0;
    case (address)
      ADDR_STATUS: begin
        readMux[STAT_NOT_EMPTY] = !fifoEmpty;
        readMux[STAT_OVERRUN]   = overrun_q;
        readMux[STAT_BUSY]      = busy;
        readMux[STAT_MISSED]    = missed_q;
      end
      ADDR_CONTROL: readMux[CTRL_WIDTH-1:0] = control_q;
      ADDR_DATA:    if (!fifoEmpty) readMux = fifoHead;
      ADDR_LEVEL:   readMux[LW-1:0] = fifoLevel;
      default:      readMux = '0;
    endcase
  end

  // readdata is re-registered every cycle from the mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readMux;
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a behavioural LTC2308 model.
module tb_adc_sample_sequencer;

  localparam int SCK_HALF    = 2;
  localparam int CONV_CYCLES = 80;
  localparam int FIFO_DEPTH  = 8;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_DATA    = 3'd2;
  localparam logic [2:0] A_LEVEL   = 3'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        trigger = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        irq;
  logic        adc_convst, adc_sck, adc_sdi, adc_sdo;

  int checkCount = 0;
  int errorCount = 0;

  // ADC model: MSB ready when CONVST falls, next bit after each SCK fall
  logic [11:0] adcWord = 12'h000;
  logic [3:0]  adcIdx = 4'd11;
  logic [11:0] sdiBits = 12'h000;
  int          sckRises = 0;
  int          sckFalls = 0;
  int          convstCycles = 0;

  assign adc_sdo = adcWord[adcIdx];

  always #5 clk = ~clk;

  always @(negedge adc_convst) adcIdx = 4'd11;

  always @(negedge adc_sck) begin
    if (adcIdx != 4'd0) adcIdx = adcIdx - 4'd1;
    sckFalls = sckFalls + 1;
  end

  always @(posedge adc_sck) begin
    sdiBits  = {sdiBits[10:0], adc_sdi};
    sckRises = sckRises + 1;
  end

  always @(posedge clk) begin
    if (adc_convst) convstCycles = convstCycles + 1;
  end

  adc_sample_sequencer #(
    .SCK_HALF    (SCK_HALF),
    .CONV_CYCLES (CONV_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trigger    (trigger),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic busRead(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clk);
    address = addr; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    data = readdata; chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] addr, input logic [15:0] expected);
    logic [15:0] value;
    busRead(addr, value);
    checkOutput(tag, value, expected);
  endtask

  // One-cycle trigger pulse
  task automatic applyStimulus();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic clearMonitors();
    sdiBits = 12'h000; sckRises = 0; sckFalls = 0; convstCycles = 0;
  endtask

  task automatic waitIdle(input string tag);
    logic [15:0] st;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      busRead(A_STATUS, st);
      if (!st[2]) done = 1'b1;
    end
    checkOutput({tag, "_idle"}, {15'd0, done}, 16'd1);
  endtask

  task automatic waitSckFalls(input string tag, input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sckFalls >= n) done = 1'b1;
    end
    checkOutput({tag, "_sck"}, {15'd0, done}, 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_readdata", readdata, 16'h0000);
    checkOutput("rst_pins", {12'd0, irq, adc_convst, adc_sck, adc_sdi}, 16'h0000);
    reset_n = 1'b1;
    readCheck("rst_status",  A_STATUS,  16'h0000);
    readCheck("rst_control", A_CONTROL, 16'h0000);
    readCheck("rst_level",   A_LEVEL,   16'h0000);
    readCheck("rst_data",    A_DATA,    16'h0000);
    readCheck("unmapped",    3'd5,      16'h0000);

    // Single conversion, channel 3 bipolar: config 1,1,0,1,0,0 then six zeros
    busWrite(A_CONTROL, 16'h000D);
    readCheck("control_rw", A_CONTROL, 16'h000D);
    clearMonitors();
    adcWord = 12'hA5C;
    applyStimulus();
    readCheck("busy_during", A_STATUS, 16'h0004);
    waitIdle("conv1");
    checkOutput("convst_len", 16'(convstCycles), 16'd80);
    checkOutput("sck_rises", 16'(sckRises), 16'd12);
    checkOutput("sdi_frame", {4'd0, sdiBits}, 16'h0D00);
    readCheck("status_ne", A_STATUS, 16'h0001);
    readCheck("level_1",   A_LEVEL,  16'h0001);
    readCheck("data_1",    A_DATA,   16'h3A5C);
    readCheck("level_0",   A_LEVEL,  16'h0000);
    readCheck("status_0",  A_STATUS, 16'h0000);

    // Second trigger while busy is dropped and flagged
    adcWord = 12'h123;
    applyStimulus();
    repeat (10) @(negedge clk);
    applyStimulus();
    readCheck("missed_busy", A_STATUS, 16'h000C);
    waitIdle("missed");
    readCheck("missed_after", A_STATUS, 16'h0009);
    readCheck("missed_level", A_LEVEL,  16'h0001);
    busWrite(A_STATUS, 16'hFFFF);
    readCheck("missed_clr",  A_STATUS, 16'h0001);
    readCheck("missed_data", A_DATA,   16'h3123);

    // Trigger with enable clear is ignored without a flag
    busWrite(A_CONTROL, 16'h000C);
    applyStimulus();
    readCheck("disabled_trig", A_STATUS, 16'h0000);

    // CONTROL rewrite mid-conversion keeps the latched channel
    busWrite(A_CONTROL, 16'h000D);
    adcWord = 12'h5A7;
    applyStimulus();
    busWrite(A_CONTROL, 16'h0010);
    waitIdle("midwrite");
    readCheck("midwrite_data", A_DATA,    16'h35A7);
    readCheck("midwrite_ctrl", A_CONTROL, 16'h0010);

    // Nine conversions on channel 5, no reads: ninth is dropped
    busWrite(A_CONTROL, 16'h0015);
    for (int i = 0; i < 9; i++) begin
      adcWord = 12'h100 + 12'(i);
      applyStimulus();
      waitIdle("fill");
    end
    readCheck("full_level",  A_LEVEL,  16'h0008);
    readCheck("full_status", A_STATUS, 16'h0003);

    // Push and pop in the same cycle while full: both happen
    busWrite(A_STATUS, 16'h0000);
    readCheck("full_clr", A_STATUS, 16'h0001);
    clearMonitors();
    adcWord = 12'h1FF;
    applyStimulus();
    waitSckFalls("pushpop", 12);
    readCheck("pushpop_data", A_DATA, 16'h5100);
    waitIdle("pushpop");
    readCheck("pushpop_status", A_STATUS, 16'h0001);
    readCheck("pushpop_level",  A_LEVEL,  16'h0008);
    for (int i = 1; i < 8; i++) begin
      readCheck("drain", A_DATA, 16'h5100 + 16'(i));
    end
    readCheck("drain_last",   A_DATA,   16'h51FF);
    readCheck("drain_level",  A_LEVEL,  16'h0000);
    readCheck("drain_status", A_STATUS, 16'h0000);

    // Interrupt follows FIFO occupancy
    busWrite(A_CONTROL, 16'h0007);
    checkOutput("irq_idle", {15'd0, irq}, 16'h0000);
    adcWord = 12'h0F0;
    applyStimulus();
    checkOutput("irq_busy", {15'd0, irq}, 16'h0000);
    waitIdle("irq");
    checkOutput("irq_set", {15'd0, irq}, 16'h0001);
    readCheck("irq_data", A_DATA, 16'h10F0);
    checkOutput("irq_clr", {15'd0, irq}, 16'h0000);
    readCheck("empty_pop", A_DATA, 16'h0000);

    // Reset in the middle of the SPI exchange, SCK high at that moment
    busWrite(A_CONTROL, 16'h000D);
    clearMonitors();
    adcWord = 12'h777;
    applyStimulus();
    waitSckFalls("abort", 3);
    repeat (SCK_HALF) @(posedge clk);
    #1;
    checkOutput("sck_pre_reset", {15'd0, adc_sck}, 16'h0001);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_pins", {13'd0, adc_convst, adc_sck, adc_sdi}, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    readCheck("abort_status",  A_STATUS,  16'h0000);
    readCheck("abort_level",   A_LEVEL,   16'h0000);
    readCheck("abort_control", A_CONTROL, 16'h0000);
    busWrite(A_CONTROL, 16'h000D);
    clearMonitors();
    adcWord = 12'h456;
    applyStimulus();
    waitIdle("after_abort");
    checkOutput("after_abort_sck", 16'(sckRises), 16'd12);
    checkOutput("after_abort_sdi", {4'd0, sdiBits}, 16'h0D00);
    readCheck("after_abort_level", A_LEVEL, 16'h0001);
    readCheck("after_abort_data",  A_DATA,  16'h3456);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
